mcpu6bit_mem_responder: RTL and testbench

//  Memory-side partner of the 6-bit minimal CPU. Generates the CPU clock and CPU reset, and

---
 rtl/mcpu6bit_mem_responder_if.sv | 38 +++
 rtl/mcpu6bit_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_mcpu6bit_mem_responder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcpu6bit_mem_responder_if.sv
// rtl/mcpu6bit_mem_responder_if.sv - CPU bus and host port bundle for the 6-bit CPU memory responder
//
// Purpose: groups the multiplexed CPU bus and the host load/inspect port.
//   slave  modport: the memory responder (drives clock/reset/read data to the CPU).
//   master modport: the CPU plus host side (drives bus data, write strobe, host access).
// Signals:
//   cpu_clk      responder -> CPU   clock to CPU
//   cpu_rst_n    responder -> CPU   CPU reset, active low
//   cpu_dataout  CPU -> responder   {2'b00,addr} while cpu_clk=1, accumulator while cpu_clk=0
//   cpu_we_n     CPU -> responder   write strobe, active low
//   cpu_datain   responder -> CPU   read data
//   host_ready   responder -> host  1 while halted
//   host_we      host -> responder  write strobe
//   host_addr    host -> responder  word address
//   host_wdata   host -> responder  write data
//   host_rdata   responder -> host  mem[host_addr]
interface mcpu6bit_mem_responder_if;
  logic       cpu_clk;
  logic       cpu_rst_n;
  logic [5:0] cpu_dataout;
  logic       cpu_we_n;
  logic [5:0] cpu_datain;
  logic       host_ready;
  logic       host_we;
  logic [3:0] host_addr;
  logic [5:0] host_wdata;
  logic [5:0] host_rdata;

  modport slave (
    output cpu_clk, cpu_rst_n, cpu_datain, host_ready, host_rdata,
    input  cpu_dataout, cpu_we_n, host_we, host_addr, host_wdata
  );

  modport master (
    input  cpu_clk, cpu_rst_n, cpu_datain, host_ready, host_rdata,
    output cpu_dataout, cpu_we_n, host_we, host_addr, host_wdata
  );
endinterface

// File: rtl/mcpu6bit_mem_responder.sv
// rtl/mcpu6bit_mem_responder.sv - memory-side partner of the 6-bit CPU: clock/reset generation and 16x6 RAM
//
// Purpose: generates cpu_clk and cpu_rst_n from the fast clock, latches the address at the end of
//   each cpu_clk high phase, returns mem[addr] during the low phase and commits stores at the end
//   of the low phase. A host port loads/inspects the RAM while the CPU clock is halted.
// Parameters:
//   HALF_DIV    fast clk cycles per cpu_clk half-period (>= 2)
//   RST_CYCLES  cpu_clk periods with cpu_rst_n low after reset release
// Ports:
//   clk      in   fast system clock
//   rst      in   asynchronous active-high reset
//   run      in   1 = free-run cpu_clk, 0 = halt at end of the current period
//   step     in   single-period request (only with MCPU_STEP_EN)
//   bus      slave modport of mcpu6bit_mem_responder_if (CPU bus + host port)
//   cyc_cnt  out  cpu_clk rising edges counted while cpu_rst_n=1, wraps
// Build option: define MCPU_STEP_EN to enable single-stepping from HALT via a 0->1 edge on step.
module mcpu6bit_mem_responder #(
  parameter int HALF_DIV   = 2,
  parameter int RST_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic                        step,
  mcpu6bit_mem_responder_if.slave     bus,
  output logic [15:0]                 cyc_cnt
);

  localparam int PH_W = (HALF_DIV < 2) ? 1 : $clog2(HALF_DIV);
  localparam int RC_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_DIV - 1);
  localparam logic [RC_W-1:0] RC_INIT = RC_W'(RST_CYCLES);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t          state_q;
  logic [PH_W-1:0] ph_q;
  logic            cpu_clk_q;
  logic            cpu_rst_n_q;
  logic [5:0]      datain_q;
  logic [3:0]      addr_q;
  logic [15:0]     cyc_q;
  logic [RC_W-1:0] rst_cnt_q;
  logic [5:0]      mem_q [16];

  logic start_d;
  logic ph_last_d;
  logic rise_d;
  logic store_d;
  logic host_ready_d;

`ifdef MCPU_STEP_EN
  logic step_q;
  logic step_qq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q  <= 1'b0;
      step_qq <= 1'b0;
    end else begin
      step_q  <= step;
      step_qq <= step_q;
    end
  end

  // The edge pulse only matters in HALT; outside HALT it is simply not looked at.
  assign start_d = run | (step_q & ~step_qq);
`else
  logic unused_step;
  assign unused_step = step;
  assign start_d     = run;
`endif

  assign ph_last_d    = (ph_q == PH_LAST);
  assign host_ready_d = (state_q == S_HALT);
  // A new period (rising cpu_clk) starts from HALT on a start request, or back-to-back from LOW
  // only while run is held; a step-started period therefore falls back to HALT by itself.
  assign rise_d  = ((state_q == S_HALT) && start_d) ||
                   ((state_q == S_LOW) && ph_last_d && run);
  // Stores are suppressed while the CPU is held in reset so its undefined strobe cannot corrupt RAM.
  assign store_d = (state_q == S_LOW) && ph_last_d && !bus.cpu_we_n && cpu_rst_n_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HALT;
      ph_q        <= '0;
      cpu_clk_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      datain_q    <= '0;
      addr_q      <= '0;
      cyc_q       <= '0;
      rst_cnt_q   <= RC_INIT;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (host_ready_d && bus.host_we) begin
        mem_q[bus.host_addr] <= bus.host_wdata;
      end
      if (store_d) begin
        mem_q[addr_q] <= bus.cpu_dataout;
      end
      if (rise_d) begin
        if (rst_cnt_q != '0) begin
          rst_cnt_q <= rst_cnt_q - 1'b1;
        end
        if (cpu_rst_n_q) begin
          cyc_q <= cyc_q + 16'd1;
        end
      end

      case (state_q)
        S_HALT: begin
          ph_q      <= '0;
          cpu_clk_q <= 1'b0;
          if (start_d) begin
            state_q   <= S_HIGH;
            cpu_clk_q <= 1'b1;
          end
        end
        S_HIGH: begin
          if (ph_last_d) begin
            // Upper bus bits during the address phase are don't-care.
            addr_q    <= bus.cpu_dataout[3:0];
            cpu_clk_q <= 1'b0;
            ph_q      <= '0;
            state_q   <= S_LOW;
            // Release CPU reset on the falling edge after the last reset period, so the next
            // rising edge is the CPU's first executing edge.
            if (rst_cnt_q == '0) begin
              cpu_rst_n_q <= 1'b1;
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        S_LOW: begin
          // Read data is captured once, one cycle into LOW, and held until the next rise;
          // a store at the end of this period does not refresh it.
          if (ph_q == '0) begin
            datain_q <= mem_q[addr_q];
          end
          if (ph_last_d) begin
            ph_q <= '0;
            if (run) begin
              state_q   <= S_HIGH;
              cpu_clk_q <= 1'b1;
            end else begin
              state_q <= S_HALT;
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        default: begin
          state_q   <= S_HALT;
          cpu_clk_q <= 1'b0;
          ph_q      <= '0;
        end
      endcase
    end
  end

  assign bus.cpu_clk    = cpu_clk_q;
  assign bus.cpu_rst_n  = cpu_rst_n_q;
  assign bus.cpu_datain = datain_q;
  assign bus.host_ready = host_ready_d;
  assign bus.host_rdata = mem_q[bus.host_addr];
  assign cyc_cnt        = cyc_q;

endmodule

// File: tb/tb_mcpu6bit_mem_responder.sv
// tb/tb_mcpu6bit_mem_responder.sv - scoreboard bench for mcpu6bit_mem_responder
module tb_mcpu6bit_mem_responder;
  localparam int HALF_DIV   = 2;
  localparam int RST_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [15:0] cyc_cnt;

  mcpu6bit_mem_responder_if bus ();

  mcpu6bit_mem_responder #(
    .HALF_DIV  (HALF_DIV),
    .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .step   (step),
    .bus    (bus),
    .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_cyc(input int kk);
    return (kk > RST_CYCLES) ? 16'(kk - RST_CYCLES) : 16'd0;
  endfunction

  // Reference model: RAM contents, count of cpu_clk rises since reset, pending expectations.
  typedef struct { logic [5:0] rd; logic rstn; logic [15:0] cyc; } exp_t;
  typedef struct { logic [3:0] a; logic we_n; logic [5:0] acc; } op_t;
  typedef struct { logic [3:0] a; logic [5:0] d; } hw_t;

  logic [5:0] mem_m [16];
  int         k = 0;
  exp_t       sbq [$];
  op_t        dirq [$];
  hw_t        hwq [$];
  op_t        cur;
  logic       last_clk = 1'b0;

  // CPU model and expectation producer: reacts to cpu_clk edges like the real CPU would.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      hwq.delete();
      k = 0;
      for (int i = 0; i < 16; i++) mem_m[i] = '0;
      last_clk = 1'b0;
      bus.cpu_we_n = 1'b1;
      bus.cpu_dataout = '0;
    end else begin
      while (hwq.size() > 0) begin
        hw_t h;
        h = hwq.pop_front();
        mem_m[h.a] = h.d;
      end
      if (bus.cpu_clk && !last_clk) begin
        k++;
        if (dirq.size() > 0) cur = dirq.pop_front();
        else begin
          cur.a    = 4'($urandom);
          cur.we_n = ($urandom_range(0, 2) != 0);
          cur.acc  = 6'($urandom);
        end
        bus.cpu_dataout = {2'($urandom), cur.a};
        bus.cpu_we_n    = 1'b1;
      end else if (!bus.cpu_clk && last_clk) begin
        exp_t e;
        e.rd   = mem_m[cur.a];
        e.rstn = (k >= RST_CYCLES);
        e.cyc  = exp_cyc(k);
        sbq.push_back(e);
        bus.cpu_dataout = cur.acc;
        bus.cpu_we_n    = cur.we_n;
        if (!cur.we_n && (k >= RST_CYCLES)) mem_m[cur.a] = cur.acc;
      end
      last_clk = bus.cpu_clk;
    end
  end

  // Monitor: at the end of every cpu_clk period compare what was presented during LOW.
  logic        m_in_low = 1'b0;
  logic [5:0]  m_rd;
  logic        m_rstn;
  logic [15:0] m_cyc;
  int          n_periods = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_in_low = 1'b0;
    end else begin
      if (m_in_low && (bus.cpu_clk || bus.host_ready)) begin
        if (sbq.size() == 0) begin
          check("sb_underflow", 32'd0, 32'd1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("cpu_datain", 32'(m_rd), 32'(e.rd));
          check("cpu_rst_n", 32'(m_rstn), 32'(e.rstn));
          check("cyc_cnt", 32'(m_cyc), 32'(e.cyc));
          n_periods++;
        end
      end
      m_in_low = !bus.cpu_clk && !bus.host_ready;
      m_rd     = bus.cpu_datain;
      m_rstn   = bus.cpu_rst_n;
      m_cyc    = cyc_cnt;
    end
  end

  task automatic host_write(input logic [3:0] a, input logic [5:0] d, input bit accept);
    bus.host_addr  = a;
    bus.host_wdata = d;
    bus.host_we    = 1'b1;
    @(negedge clk);
    bus.host_we = 1'b0;
    if (accept) hwq.push_back('{a: a, d: d});
  endtask

  task automatic dump(input string tag);
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      bus.host_addr = 4'(a);
      #1;
      check($sformatf("%s_rdata[%0d]", tag, a), 32'(bus.host_rdata), 32'(mem_m[a]));
    end
    @(negedge clk);
  endtask

  task automatic wait_clk_hi(input int max, input string nm);
    int n = 0;
    while (bus.cpu_clk !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(bus.cpu_clk), 32'd1);
  endtask

  task automatic wait_halt(input int max, input string nm);
    int n = 0;
    while (bus.host_ready !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(bus.host_ready), 32'd1);
  endtask

  initial begin
    int kb;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_cpu_clk", 32'(bus.cpu_clk), 32'd0);
    check("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    check("rst_cpu_datain", 32'(bus.cpu_datain), 32'd0);
    check("rst_cyc_cnt", 32'(cyc_cnt), 32'd0);
    check("rst_host_ready", 32'(bus.host_ready), 32'd1);
    dump("rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("halt_no_clk", 32'(bus.cpu_clk), 32'd0);

    host_write(4'd3, 6'h2A, 1'b1);
    bus.host_addr = 4'd3;
    #1 check("host_load_3", 32'(bus.host_rdata), 32'h2A);
    @(negedge clk);
    host_write(4'd7, 6'h15, 1'b1);
    host_write(4'(($urandom % 16)), 6'($urandom), 1'b1);
    @(negedge clk);

    dirq.push_back('{a: 4'd7, we_n: 1'b0, acc: 6'h3F});  // blocked: CPU still in reset
    dirq.push_back('{a: 4'd3, we_n: 1'b1, acc: 6'h00});
    dirq.push_back('{a: 4'd7, we_n: 1'b1, acc: 6'h00});
    dirq.push_back('{a: 4'd0, we_n: 1'b1, acc: 6'h00});
    dirq.push_back('{a: 4'd5, we_n: 1'b0, acc: 6'h11});
    dirq.push_back('{a: 4'd5, we_n: 1'b1, acc: 6'h00});
    run = 1'b1;
    repeat (40) @(negedge clk);
    host_write(4'd3, 6'h00, 1'b0);  // dropped while running
    host_write(4'd5, 6'h3C, 1'b0);
    repeat (80) @(negedge clk);

    // Drop run mid-HIGH: the period must complete and the clock park low.
    wait_clk_hi(20, "high_seen");
    run = 1'b0;
    wait_halt(20, "halt_after_drop");
    repeat (6) @(negedge clk);
    check("parked_clk", 32'(bus.cpu_clk), 32'd0);
    check("parked_ready", 32'(bus.host_ready), 32'd1);
    check("parked_cyc", 32'(cyc_cnt), 32'(exp_cyc(k)));
    dump("halt1");

    for (int i = 0; i < 3; i++) host_write(4'($urandom), 6'($urandom), 1'b1);
    run = 1'b1;
    wait_clk_hi(10, "resume_rise");
    for (int i = 0; i < 15; i++) begin
      run = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 24)) @(negedge clk);
    end
    run = 1'b0;
    wait_halt(20, "halt2");
    repeat (4) @(negedge clk);
    dump("halt2");

    kb = k;
`ifdef MCPU_STEP_EN
    step = 1'b1;
    wait_clk_hi(10, "step_rise");
    wait_halt(20, "step_halt");
    repeat (6) @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    check("step_one_rise", 32'(k), 32'(kb + 1));
    check("step_cyc", 32'(cyc_cnt), 32'(exp_cyc(kb + 1)));
    check("step_ready", 32'(bus.host_ready), 32'd1);
`else
    step = 1'b1;
    repeat (4) @(negedge clk);
    step = 1'b0;
    repeat (10) @(negedge clk);
    check("step_ignored_k", 32'(k), 32'(kb));
    check("step_ignored_cyc", 32'(cyc_cnt), 32'(exp_cyc(kb)));
    check("step_ignored_ready", 32'(bus.host_ready), 32'd1);
`endif

    // Reset in the middle of a HIGH phase.
    run = 1'b1;
    wait_clk_hi(20, "pre_rst_high");
    #2 rst = 1'b1;
    bus.host_addr = 4'd3;
    #1;
    check("async_cpu_clk", 32'(bus.cpu_clk), 32'd0);
    check("async_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    check("async_ram_clear", 32'(bus.host_rdata), 32'd0);
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run = 1'b1;
    repeat (48) @(negedge clk);
    run = 1'b0;
    wait_halt(20, "halt3");
    repeat (4) @(negedge clk);
    dump("halt3");
    check("sb_drained", 32'(sbq.size()), 32'd0);
    check("enough_periods", 32'(n_periods >= 40), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
